// File: rtl/elevator_scheduler_if.sv
// Call-button / car-status bundle between the elevator scheduler and its user.
// ELEV_FIRE_RECALL_EN adds the fire-service input and recall indication.
interface elevator_scheduler_if;
   logic [3:1] i_p;      // floor buttons, active-low
   logic [3:1] o_floor;  // one-hot car position
   logic       o_door;
   logic       o_up;
   logic       o_dn;
   logic [3:1] o_calls;
   logic       o_busy;
`ifdef ELEV_FIRE_RECALL_EN
   logic       i_fire;
   logic       o_recall;
`endif

   modport master (
`ifdef ELEV_FIRE_RECALL_EN
      output i_fire,
      input  o_recall,
`endif
      output i_p,
      input  o_floor, o_door, o_up, o_dn, o_calls, o_busy
   );

   modport slave (
`ifdef ELEV_FIRE_RECALL_EN
      input  i_fire,
      output o_recall,
`endif
      input  i_p,
      output o_floor, o_door, o_up, o_dn, o_calls, o_busy
   );
endinterface

// File: rtl/elevator_scheduler.sv
// Collective scheduler for a 3-floor car: latches calls, times travel and door dwell.
// Optional fire-service recall to floor 1 is enabled by defining ELEV_FIRE_RECALL_EN.
module elevator_scheduler #(
   parameter int TRAVEL_CYC = 8,
   parameter int DOOR_CYC   = 6,
   parameter int CNT_W      = 8
) (
   input  logic                 i_clk,
   input  logic                 i_clr,
   elevator_scheduler_if.slave  io_bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_DOOR, ST_MOVE} state_t;

   localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
   localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYC - 1);

   state_t           r_state,  w_state_nx;
   logic [3:1]       r_floor,  w_floor_nx;
   logic [3:1]       r_calls,  w_calls_nx;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
   logic             r_dir_up, w_dir_up_nx;

   logic [3:1] w_press_eff, w_calls_set, w_clear;
   logic [3:1] w_above, w_below, w_floor_step, w_above_new, w_below_new;
   logic       w_ahead_cur, w_behind_cur, w_ahead_new, w_stop_new, w_arrive;
   logic       w_fire_act;

   // Presses at the open-door floor are dropped; a press lands in the same edge's decision on arrival.
   assign w_press_eff  = ~io_bus.i_p & ((r_state == ST_DOOR) ? ~r_floor : 3'b111);
   assign w_calls_set  = r_calls | w_press_eff;

   assign w_above      = {r_floor[1] | r_floor[2], r_floor[1], 1'b0};
   assign w_below      = {1'b0, r_floor[3], r_floor[2] | r_floor[3]};
   assign w_ahead_cur  = |(r_calls & (r_dir_up ? w_above : w_below));
   assign w_behind_cur = |(r_calls & (r_dir_up ? w_below : w_above));

   assign w_floor_step = r_dir_up ? {r_floor[2:1], 1'b0} : {1'b0, r_floor[3:2]};
   assign w_above_new  = {w_floor_step[1] | w_floor_step[2], w_floor_step[1], 1'b0};
   assign w_below_new  = {1'b0, w_floor_step[3], w_floor_step[2] | w_floor_step[3]};
   assign w_ahead_new  = |(w_calls_set & (r_dir_up ? w_above_new : w_below_new));
   assign w_stop_new   = |(w_calls_set & w_floor_step);
   assign w_arrive     = (r_state == ST_MOVE) && (r_cnt == TRAVEL_LAST);

`ifdef ELEV_FIRE_RECALL_EN
   logic r_recall, w_recall_nx;
   assign w_fire_act      = io_bus.i_fire | r_recall;
   assign io_bus.o_recall = r_recall;
`else
   assign w_fire_act = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_state_nx  = r_state;
      w_floor_nx  = r_floor;
      w_cnt_nx    = r_cnt;
      w_dir_up_nx = r_dir_up;
      w_clear     = 3'b000;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nx = '0;
            if (|(r_calls & r_floor)) begin
               w_state_nx = ST_DOOR;
               w_clear    = r_floor;
            end else if (w_ahead_cur) begin
               w_state_nx = ST_MOVE;
            end else if (w_behind_cur) begin
               w_dir_up_nx = ~r_dir_up;
               w_state_nx  = ST_MOVE;
            end
         end
         ST_MOVE: begin
            if (w_arrive) begin
               w_floor_nx = w_floor_step;
               w_cnt_nx   = '0;
               if (w_stop_new) begin
                  w_state_nx = ST_DOOR;
                  w_clear    = w_floor_step;
               end else if (!w_ahead_new) begin
                  w_state_nx = ST_IDLE;
               end
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         ST_DOOR: begin
            if (r_cnt == DOOR_LAST) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
      endcase

      // Clear wins over a same-edge set of the same bit.
      w_calls_nx = w_calls_set & ~w_clear;

`ifdef ELEV_FIRE_RECALL_EN
      w_recall_nx = io_bus.i_fire | (r_recall & ~((r_state == ST_DOOR) & r_floor[1]));
      if (w_fire_act) begin
         // Recall overrides the normal schedule: head for floor 1 and hold the door there.
         w_calls_nx = 3'b000;
         case (r_state)
            ST_MOVE: begin
               if (w_arrive) begin
                  w_floor_nx  = w_floor_step;
                  w_cnt_nx    = '0;
                  w_dir_up_nx = 1'b0;
                  w_state_nx  = w_floor_step[1] ? ST_DOOR : ST_MOVE;
               end else begin
                  w_cnt_nx   = r_cnt + 1'b1;
                  w_state_nx = ST_MOVE;
               end
            end
            ST_DOOR: begin
               w_cnt_nx   = '0;
               w_state_nx = (r_floor[1] && io_bus.i_fire) ? ST_DOOR : ST_IDLE;
            end
            default: begin
               w_cnt_nx    = '0;
               w_dir_up_nx = 1'b0;
               w_state_nx  = r_floor[1] ? ST_DOOR : ST_MOVE;
            end
         endcase
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state  <= ST_IDLE;
         r_floor  <= 3'b001;
         r_calls  <= 3'b000;
         r_cnt    <= '0;
         r_dir_up <= 1'b1;
`ifdef ELEV_FIRE_RECALL_EN
         r_recall <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nx;
         r_floor  <= w_floor_nx;
         r_calls  <= w_calls_nx;
         r_cnt    <= w_cnt_nx;
         r_dir_up <= w_dir_up_nx;
`ifdef ELEV_FIRE_RECALL_EN
         r_recall <= w_recall_nx;
`endif
      end
   end

   assign io_bus.o_floor = r_floor;
   assign io_bus.o_door  = (r_state == ST_DOOR);
   assign io_bus.o_up    = (r_state == ST_MOVE) &&  r_dir_up;
   assign io_bus.o_dn    = (r_state == ST_MOVE) && !r_dir_up;
   assign io_bus.o_calls = r_calls;
   assign io_bus.o_busy  = (r_state != ST_IDLE);

   // An arrival with no stop and nothing ahead should never happen outside recall.
   a_no_dead_arrival: assert property (@(posedge i_clk) disable iff (i_clr)
      !(w_arrive && !w_fire_act && !w_stop_new && !w_ahead_new));
   a_floor_onehot: assert property (@(posedge i_clk) disable iff (i_clr) $onehot(r_floor));

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Sequencing controller for the 3-floor elevator: latches hall calls, chooses direction, times floor-to-floor travel and door dwell, and clears serviced calls.
- Sits above the elevator next-state/reset logic. It replaces the free-running call/reset handling with a clocked scheduler that owns the pending-call register and the car position.
- Scheduling is collective: the car keeps its direction while calls exist ahead of it, then reverses.

Parameters:
- TRAVEL_CYC, 8, clock cycles to move one floor (>=2).
- DOOR_CYC, 6, clock cycles the door stays open per stop (>=1).
- CNT_W, 8, width of the shared travel/door counter; must hold max(TRAVEL_CYC, DOOR_CYC).

Ports:
- CLK  input  1  single clock, all state on posedge.
- CLR  input  1  synchronous active-high reset.
- P  input  [3:1]  floor buttons, active-low (0 = pressed, 1 = released).
- FLOOR  output  [3:1]  one-hot current car floor.
- DOOR  output  1  door open.
- UP  output  1  car moving up.
- DN  output  1  car moving down.
- CALLS  output  [3:1]  latched pending calls (the B vector).
- BUSY  output  1  state != IDLE.

Behaviour:
- Reset (CLR=1 at posedge):
  - State IDLE.
  - FLOOR=3'b001, DOOR=0, UP=0, DN=0, CALLS=3'b000, BUSY=0.
  - Counter=0, direction flag=up.
  - CLR overrides all other activity, including mid-move or door open.
- Call latch:
  - P[f]=0 sampled at a posedge sets CALLS[f] that edge; visible the next cycle.
  - A press of the current floor is ignored while in DOOR.
  - A button held past door close re-latches and reopens the door.
- States: IDLE, DOOR, MOVE.
- IDLE:
  - CALLS[cur]=1: go to DOOR and clear CALLS[cur] on the same edge.
  - Otherwise, with calls ahead in the direction flag: MOVE that way.
  - Otherwise, with calls behind: flip the flag, then MOVE.
  - Tie at floor 2 with calls at 1 and 3 after reset: up.
  - No calls: stay IDLE.
- MOVE:
  - UP or DN asserted (exactly one); counter increments each cycle.
  - At count TRAVEL_CYC-1, FLOOR shifts one position and the counter resets.
  - On the arrival edge, if CALLS[new] (sampled including any same-edge press): DOOR, clear CALLS[new], UP=DN=0.
  - Else, if calls remain ahead: continue MOVE.
  - Else: IDLE. Unreachable by construction; flagged by assertion.
- DOOR:
  - DOOR=1 for exactly DOOR_CYC cycles.
  - Then IDLE with DOOR=0; the next decision is made in IDLE one cycle later.
- Floor-to-floor latency: TRAVEL_CYC cycles from MOVE entry to FLOOR change.
- Boundaries:
  - FLOOR never leaves one-hot; no move past floor 3 or below floor 1.
  - UP and DN are never both 1; DOOR and UP|DN are never both 1.
  - Simultaneous set and clear of the same CALLS bit: clear wins.

Optional Feature:
- Macro: ELEV_FIRE_RECALL_EN.
- Defined: adds input FIRE (1 bit, active-high) and output RECALL (1 bit).
  - FIRE=1 sets RECALL and clears CALLS; new presses are ignored.
  - In MOVE up: the car finishes the current floor segment, then reverses toward floor 1.
  - In DOOR: the dwell aborts next cycle.
  - The car travels to floor 1, opens the door, and holds DOOR=1 until FIRE=0.
  - After FIRE=0: IDLE, RECALL=0.
- Undefined: no FIRE/RECALL ports; behaviour exactly as above.

Test Plan:
- Params TRAVEL_CYC=4, DOOR_CYC=3.
- Reset idle: CLR=1 for 2 cycles, P=3'b111 -> FLOOR=001, DOOR=0, UP=DN=0, CALLS=000, BUSY=0; stays idle 20 cycles.
- Call at current floor: P[1]=0 for 1 cycle -> CALLS[1]=1 next cycle; DOOR=1 for exactly 3 cycles; CALLS=000; FLOOR stays 001.
- Travel and stop:
  - Stimulus: from floor 1, pulse P[3]=0.
  - UP=1; FLOOR=010 after 4 cycles, no stop; FLOOR=100 after 8 cycles.
  - DOOR=1 for 3 cycles; CALLS[3] cleared on the arrival edge.
- Intermediate pickup:
  - Stimulus: moving up 1->3, press P[2] at count 1 of the first segment.
  - Car stops at 010 with DOOR=1 for 3 cycles.
  - Then resumes UP to 100 and serves floor 3.
- Reversal:
  - Stimulus: at floor 3 in DOOR, press P[1] and P[2] together.
  - After the door closes: DN=1; stops at 010, then 001.
  - CALLS is 000 at the end.
- Reset mid-move: CLR=1 while UP=1 at count 2 -> next cycle FLOOR=001, UP=0, CALLS=000, state IDLE.
